// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the LSU alignment logic.
package dmem_pkg;

  // Access size encodings, taken directly from funct3[1:0].
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // A half access must sit on a 2-byte boundary and a word on a 4-byte boundary.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // size 11 has no meaning on this bus.
  function automatic logic size_illegal(input logic [1:0] size);
    return size == 2'b11;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// LSU <-> data memory request/response channels (valid/ready on each).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering for RISC-V loads/stores: store byte enables and lane-replicated
// write data, plus shift-down and sign/zero extension of a raw read word.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;
  logic        sx;

  // Store side: replicate the LSB-aligned data so every lane sees its byte; be picks lanes.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Load side: bring the addressed lane(s) down to bit 0 and extend.
  always_comb begin
    shifted   = rdata_raw >> {addr_lo, 3'b000};
    sx        = 1'b0;
    rdata_ext = 32'h0;
    case (size)
      SZ_BYTE: begin
        sx        = ~is_unsigned & shifted[7];
        rdata_ext = {{24{sx}}, shifted[7:0]};
      end
      SZ_HALF: begin
        sx        = ~is_unsigned & shifted[15];
        rdata_ext = {{16{sx}}, shifted[15:0]};
      end
      SZ_WORD: rdata_ext = rdata_raw;
      default: rdata_ext = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
// The SRAM access (write or read) happens on the edge that enters RESP, so a
// reset during WAIT drops a store cleanly, and a long RESP never re-writes.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_responder_if.slave   bus
);

  localparam int         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_CNT = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        access;
  logic        cur_we, cur_uns, cur_err;
  logic [31:0] cur_addr, cur_wdata;
  logic [1:0]  cur_size;
  logic [ADDR_WIDTH-1:0] idx;
  logic        mem_we;

  logic [3:0]  be;
  logic [31:0] wdata_rep, rdata_ext;

  logic [31:0] mem [DEPTH];
  logic [31:0] mem_rdata_q;

  // With LATENCY=0 the access coincides with the accept edge, so the live request
  // must feed the datapath while idle; otherwise the latched copy does.
  always_comb begin
    if (state_q == S_IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_size  = bus.req_size;
      cur_uns   = bus.req_unsigned;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_size  = size_q;
      cur_uns   = uns_q;
      cur_wdata = wdata_q;
    end
    cur_err = size_illegal(cur_size) | misaligned(cur_size, cur_addr[1:0]) |
              ((cur_addr >> (ADDR_WIDTH + 2)) != 32'h0);
    idx     = cur_addr[ADDR_WIDTH+1:2];
    mem_we  = access & cur_we & ~cur_err;
  end

  lsu_align u_align (
    .addr_lo     (cur_addr[1:0]),
    .size        (cur_size),
    .is_unsigned (cur_uns),
    .wdata       (cur_wdata),
    .rdata_raw   (mem_rdata_q),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext)
  );

  // Next state, wait counter and access strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          cnt_d = LAT_CNT;
          if (LAT_CNT == 4'd0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          access  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture on accept, error capture on access; both held through RESP.
  always_comb begin
    we_d    = we_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    err_d   = access ? cur_err : err_q;
    if (state_q == S_IDLE && bus.req_valid) begin
      we_d    = bus.req_we;
      addr_d  = bus.req_addr;
      size_d  = bus.req_size;
      uns_d   = bus.req_unsigned;
      wdata_d = bus.req_wdata;
    end
  end

  // Control and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // SRAM: per-lane byte writes and a registered read, both only on the access edge.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
    end
    if (access) mem_rdata_q <= mem[idx];
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_err   = (state_q == S_RESP) & err_q;
  // Stores and errors return zero; outside RESP the bus reads zero too.
  assign bus.resp_rdata = (state_q == S_RESP && !we_q && !err_q) ? rdata_ext : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Drives two responders (LATENCY=2 and LATENCY=0) with identical traffic and
// checks both against fixed vectors, hand sequences and a byte-level memory model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder_if ia ();
  dmem_responder_if iz ();

  assign ia.req_valid = req_valid;   assign iz.req_valid = req_valid;
  assign ia.req_we = req_we;         assign iz.req_we = req_we;
  assign ia.req_addr = req_addr;     assign iz.req_addr = req_addr;
  assign ia.req_size = req_size;     assign iz.req_size = req_size;
  assign ia.req_unsigned = req_unsigned; assign iz.req_unsigned = req_unsigned;
  assign ia.req_wdata = req_wdata;   assign iz.req_wdata = req_wdata;
  assign ia.resp_ready = resp_ready; assign iz.resp_ready = resp_ready;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(ia));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(0)) dutz (.clk(clk), .rst_n(rst_n), .bus(iz));

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tv[$];
  logic [31:0] model_mem [1024];

  function automatic vec_t mk(bit we, logic [31:0] addr, logic [1:0] size, bit uns,
                              logic [31:0] wdata, logic [31:0] exp_rd, bit exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns;
    v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as bytes, access of 2^size bytes starting at addr.
  task automatic model_access(input bit we, input logic [31:0] addr, input logic [1:0] size,
                              input bit uns, input logic [31:0] wdata,
                              output logic [31:0] rd, output bit err);
    int nbytes, idx, off;
    logic [31:0] w, v;
    nbytes = 1 << size;
    idx    = int'((addr / 4) % 1024);
    off    = int'(addr % 4);
    err    = (size == 3) || (size == 1 && addr % 2 != 0) ||
             (size == 2 && addr % 4 != 0) || (addr >= 32'h1000);
    rd     = 0;
    if (err) return;
    w = model_mem[idx];
    if (we) begin
      for (int b = 0; b < nbytes; b++) begin
        w = w & ~(32'hFF << (8 * (off + b)));
        w = w | (((wdata >> (8 * b)) & 32'hFF) << (8 * (off + b)));
      end
      model_mem[idx] = w;
    end else begin
      v = 0;
      for (int b = 0; b < nbytes; b++)
        v = v | (((w >> (8 * (off + b))) & 32'hFF) << (8 * b));
      if (!uns && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFFFFFF << (8 * nbytes));
      rd = v;
    end
  endtask

  // One full transaction on both DUTs; latency is edges from accept to resp_valid (-1 = none).
  task automatic xact(input bit we, input logic [31:0] addr, input logic [1:0] size,
                      input bit uns, input logic [31:0] wdata,
                      output logic [31:0] rd_a, output bit er_a, output int lat_a,
                      output logic [31:0] rd_z, output bit er_z, output int lat_z);
    int n;
    rd_a = 0; er_a = 0; lat_a = -1; rd_z = 0; er_z = 0; lat_z = -1;
    @(negedge clk);
    n = 0;
    while (!(ia.req_ready && iz.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 0;
    for (n = 0; n <= 32; n++) begin
      if (lat_a < 0 && ia.resp_valid) begin lat_a = n; rd_a = ia.resp_rdata; er_a = ia.resp_err; end
      if (lat_z < 0 && iz.resp_valid) begin lat_z = n; rd_z = iz.resp_rdata; er_z = iz.resp_err; end
      if (lat_a >= 0 && lat_z >= 0) break;
      @(posedge clk); #1;
    end
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

  task automatic run_check(input string tag, input bit we, input logic [31:0] addr,
                           input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                           input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] ra, rz;
    bit ea, ez;
    int la, lz;
    xact(we, addr, size, uns, wdata, ra, ea, la, rz, ez, lz);
    chk({tag, " lat2 latency"}, 32'(la), 32'd2);
    chk({tag, " lat2 rdata"}, ra, exp_rd);
    chk({tag, " lat2 err"}, 32'(ea), 32'(exp_err));
    chk({tag, " lat0 latency"}, 32'(lz), 32'd0);
    chk({tag, " lat0 rdata"}, rz, exp_rd);
    chk({tag, " lat0 err"}, 32'(ez), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] ra, rz, erd;
    bit ea, ez, eerr;
    int la, lz;

    tv.push_back(mk(1, 32'h10, 2, 0, 32'hDEADBEEF, 32'h0, 0));
    tv.push_back(mk(0, 32'h10, 2, 0, 32'h0, 32'hDEADBEEF, 0));
    tv.push_back(mk(1, 32'h10, 2, 0, 32'h0, 32'h0, 0));
    tv.push_back(mk(1, 32'h13, 0, 0, 32'h80, 32'h0, 0));
    tv.push_back(mk(0, 32'h10, 2, 0, 32'h0, 32'h80000000, 0));
    tv.push_back(mk(0, 32'h13, 0, 0, 32'h0, 32'hFFFFFF80, 0));
    tv.push_back(mk(0, 32'h13, 0, 1, 32'h0, 32'h00000080, 0));
    tv.push_back(mk(1, 32'h20, 2, 0, 32'h5555AAAA, 32'h0, 0));
    tv.push_back(mk(1, 32'h22, 1, 0, 32'hFFFF1234, 32'h0, 0));
    tv.push_back(mk(0, 32'h20, 2, 0, 32'h0, 32'h1234AAAA, 0));
    tv.push_back(mk(0, 32'h21, 1, 0, 32'h0, 32'h0, 1));
    tv.push_back(mk(1, 32'h21, 1, 0, 32'hBEEF, 32'h0, 1));
    tv.push_back(mk(0, 32'h20, 2, 0, 32'h0, 32'h1234AAAA, 0));
    tv.push_back(mk(0, 32'h22, 1, 0, 32'h0, 32'h00001234, 0));
    tv.push_back(mk(1, 32'h20, 1, 0, 32'h8001, 32'h0, 0));
    tv.push_back(mk(0, 32'h20, 1, 0, 32'h0, 32'hFFFF8001, 0));
    tv.push_back(mk(0, 32'h20, 1, 1, 32'h0, 32'h00008001, 0));
    tv.push_back(mk(0, 32'h21, 0, 0, 32'h0, 32'hFFFFFF80, 0));
    tv.push_back(mk(1, 32'h0, 2, 0, 32'h11111111, 32'h0, 0));
    tv.push_back(mk(1, 32'h1000, 2, 0, 32'hCAFEF00D, 32'h0, 1));
    tv.push_back(mk(0, 32'h0, 2, 0, 32'h0, 32'h11111111, 0));
    tv.push_back(mk(0, 32'h0, 3, 0, 32'h0, 32'h0, 1));
    tv.push_back(mk(1, 32'h2, 2, 0, 32'h22222222, 32'h0, 1));
    tv.push_back(mk(0, 32'hFFFFFFFC, 2, 0, 32'h0, 32'h0, 1));
    tv.push_back(mk(1, 32'h1, 0, 0, 32'hFFFFFFA5, 32'h0, 0));
    tv.push_back(mk(0, 32'h0, 2, 0, 32'h0, 32'h1111A511, 0));

    // Reset state while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(ia.req_ready), 32'd1);
    chk("reset resp_valid", 32'(ia.resp_valid), 32'd0);
    chk("reset resp_rdata", ia.resp_rdata, 32'h0);
    chk("reset resp_err", 32'(ia.resp_err), 32'd0);
    chk("reset lat0 req_ready", 32'(iz.req_ready), 32'd1);
    chk("reset lat0 resp_valid", 32'(iz.resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < tv.size(); i++)
      run_check($sformatf("vec%0d", i), tv[i].we, tv[i].addr, tv[i].size, tv[i].uns,
                tv[i].wdata, tv[i].exp_rd, tv[i].exp_err);

    // Back-pressure: hold RESP for 5 cycles while offering a store that must be ignored.
    @(negedge clk);
    req_valid = 1; req_we = 0; req_addr = 32'h10; req_size = 2; req_unsigned = 0;
    @(posedge clk); #1;
    req_valid = 0;
    begin
      int n;
      n = 0;
      while (!ia.resp_valid && n < 10) begin @(posedge clk); #1; n++; end
      chk("bp resp arrives", 32'(n), 32'd2);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1; req_we = 1; req_addr = 32'h10; req_size = 2; req_wdata = 32'h0BADF00D;
      @(posedge clk); #1;
      chk($sformatf("bp%0d resp_valid", c), 32'(ia.resp_valid), 32'd1);
      chk($sformatf("bp%0d rdata", c), ia.resp_rdata, 32'h80000000);
      chk($sformatf("bp%0d err", c), 32'(ia.resp_err), 32'd0);
      chk($sformatf("bp%0d req_ready", c), 32'(ia.req_ready), 32'd0);
      chk($sformatf("bp%0d lat0 rdata", c), iz.resp_rdata, 32'h80000000);
      chk($sformatf("bp%0d lat0 req_ready", c), 32'(iz.req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 0; resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
    chk("bp after hs resp_valid", 32'(ia.resp_valid), 32'd0);
    chk("bp after hs req_ready", 32'(ia.req_ready), 32'd1);
    run_check("bp readback", 0, 32'h10, 2, 0, 32'h0, 32'h80000000, 0);

    // Reset mid-operation: LATENCY=2 store is still waiting, LATENCY=0 store already landed.
    run_check("rst prefill", 1, 32'h30, 2, 0, 32'hAAAA5555, 32'h0, 0);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h30; req_size = 2; req_wdata = 32'h77777777;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rst pre lat2 in wait", 32'(ia.req_ready), 32'd0);
    rst_n = 0;
    #1;
    chk("rst lat2 resp_valid", 32'(ia.resp_valid), 32'd0);
    chk("rst lat2 req_ready", 32'(ia.req_ready), 32'd1);
    chk("rst lat0 resp_valid", 32'(iz.resp_valid), 32'd0);
    chk("rst lat0 req_ready", 32'(iz.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1;
    xact(0, 32'h30, 2, 0, 32'h0, ra, ea, la, rz, ez, lz);
    chk("rst readback lat2 old", ra, 32'hAAAA5555);
    chk("rst readback lat0 new", rz, 32'h77777777);

    // Random traffic against the byte model over words 64..79.
    for (int w = 64; w < 80; w++) begin
      logic [31:0] d;
      d = $urandom;
      model_access(1, 32'(w * 4), 2, 0, d, erd, eerr);
      xact(1, 32'(w * 4), 2, 0, d, ra, ea, la, rz, ez, lz);
    end
    for (int i = 0; i < 80; i++) begin
      bit we, uns;
      logic [31:0] addr, wd;
      logic [1:0] sz;
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      addr = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(12, 31));
      model_access(we, addr, sz, uns, wd, erd, eerr);
      run_check($sformatf("rnd%0d", i), we, addr, sz, uns, wd, erd, eerr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder that serves load/store requests from the core's LSU over a valid/ready request channel and a valid/ready response channel.
- Provides programmable wait states, byte/half/word access with RISC-V lane alignment and sign/zero extension, and error reporting.
- Replaces the zero-latency combinational data memory in the multi-cycle and pipelined core variants; sits between the core's memory stage and on-chip SRAM.

Parameters:
- ADDR_WIDTH, 10, word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, wait cycles between request accept and response valid. Legal range 0..15.

Ports:
- clk  input  1  clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  00 byte, 01 half, 10 word (funct3[1:0]).
- req_unsigned  input  1  load zero-extends when 1 (funct3[2]).
- req_wdata  input  32  store data, LSB-aligned.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  misaligned, out-of-range or illegal size.

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, FSM=IDLE. Memory array is not reset.
- FSM states: IDLE, WAIT, RESP. Only one request is outstanding at a time; there is no pipelining.
- IDLE: req_ready=1. When req_valid is high at a clock edge, latch we/addr/size/unsigned/wdata and load the wait counter with LATENCY.
  - LATENCY=0: go directly to RESP.
  - Otherwise: go to WAIT.
- WAIT: req_ready=0. Decrement the counter each cycle. On the edge where counter==1, perform the access and enter RESP.
- Access timing: the access happens on the edge that enters RESP. Store writes and load reads both occur on that edge. resp_valid rises exactly LATENCY edges after the accept edge.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable until resp_ready is high at a clock edge, then return to IDLE.
  - resp_ready high at that edge drops resp_valid in the following cycle.
  - The next request can be accepted no earlier than the cycle after the response handshake (req_ready=0 in RESP).
- Error conditions (error access: no memory write, resp_rdata=0, resp_err=1):
  - size=11;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - addr[31:ADDR_WIDTH+2] != 0.
- Word index: addr[ADDR_WIDTH+1:2].
- Store byte enables:
  - byte: one lane at addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes.
  - wdata is replicated across lanes; unselected bytes are unchanged.
- Load: select the lane(s) by addr[1:0], shift to bit 0, then sign-extend from bit 7/15 (req_unsigned=0) or zero-extend.
- Request inputs are ignored while req_ready=0. A store's write occurs once regardless of how long RESP is held.
- Reset asserted mid-operation: FSM returns to IDLE immediately and the pending request is dropped.
  - A store not yet performed is not written.
  - A store already performed stays written.
- Memory is sized 2^ADDR_WIDTH x 32 with 4 byte-wide write lanes and is SRAM-inferable.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state enum (IDLE/WAIT/RESP);
  - function for misalignment check.
- One combinational sub-module, lsu_align:
  - inputs addr[1:0], size, unsigned, wdata, raw read word;
  - outputs byte enables, lane-replicated store data, extended load data.
  - Shared with the core's future cached LSU.

Test Plan:
- LATENCY=2, store word 0xDEADBEEF @0x10, then load word @0x10 with resp_ready=1 → resp_valid rises 2 edges after each accept; rdata=0xDEADBEEF, err=0.
- Store byte 0x80 @0x13 over 0x00000000 → word reads 0x80000000. Load byte signed @0x13 → 0xFFFFFF80; unsigned → 0x00000080.
- Store half 0x1234 @0x22 → word @0x20 reads 0x1234xxxx with low half unchanged. Load half @0x21 → err=1, rdata=0, memory unchanged.
- Address 0x00001000 with ADDR_WIDTH=10 → err=1; a subsequent load at that word's alias @0x0 shows no write.
- Back-pressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid, rdata and err stay stable, req_ready=0, and a new req_valid is ignored. After handshake, IDLE accepts the next request.
- LATENCY=0 load → resp_valid the cycle after accept. Separately, assert rst_n=0 during WAIT of a store → resp_valid=0 and req_ready=1 after reset, and a readback shows the old data.
